// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the five-stage RISC-V pipeline.
//   XLEN     : datapath / register width
//   NREG     : architectural integer register count (5-bit specifiers)
//   REG_ZERO : specifier of the hardwired-zero register x0
//   reg_addr_t : register specifier type
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/wb_select.sv
// ---------------------------------------------------------------------------
// wb_select
//   Writeback value selection and commit decode. It is shared with the
//   forwarding unit so both agree on what retires and with which value.
//   MemToReg  in  : 1 selects ReadData, 0 selects AluResult
//   RegWrite  in  : writeback enable
//   ReadData  in  : load data from MEM/WB
//   AluResult in  : ALU result from MEM/WB
//   rd        in  : destination register
//   WriteData out : selected writeback value (valid regardless of RegWrite)
//   commitEn  out : RegWrite and rd != x0
// ---------------------------------------------------------------------------
module wb_select
  import riscv_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic [XLEN_P-1:0] ReadData,
  input  logic [XLEN_P-1:0] AluResult,
  input  reg_addr_t         rd,
  output logic [XLEN_P-1:0] WriteData,
  output logic              commitEn
);

  // Result mux and commit decode. RegWrite gates first so an unknown rd
  // while RegWrite is low still yields a clean 0 enable.
  always_comb begin
    WriteData = AluResult;
    commitEn  = 1'b0;
    if (MemToReg) begin
      WriteData = ReadData;
    end else begin
      WriteData = AluResult;
    end
    if (RegWrite) begin
      commitEn = (rd != REG_ZERO);
    end else begin
      commitEn = 1'b0;
    end
  end

endmodule : wb_select

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback sink: commits MEM/WB results into the integer register file,
//   serves the two ID-stage read ports with write-first bypass and counts
//   committed writes.
//   clk        in  : pipeline clock, rising edge
//   reset      in  : asynchronous active-low reset
//   MemToReg   in  : 1 selects ReadData, 0 selects AluResult
//   RegWrite   in  : writeback enable
//   ReadData   in  : load data from MEM/WB
//   AluResult  in  : ALU result from MEM/WB
//   rd         in  : destination register
//   rs1, rs2   in  : read port addresses
//   ReadData1  out : read port 1 (combinational, bypassed)
//   ReadData2  out : read port 2 (combinational, bypassed)
//   WriteData  out : selected writeback value, for the forwarding unit
//   WriteCount out : committed writes since reset, wraps
// ---------------------------------------------------------------------------
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemToReg,
  input  logic              RegWrite,
  input  logic [XLEN_P-1:0] ReadData,
  input  logic [XLEN_P-1:0] AluResult,
  input  reg_addr_t         rd,
  input  reg_addr_t         rs1,
  input  reg_addr_t         rs2,
  output logic [XLEN_P-1:0] ReadData1,
  output logic [XLEN_P-1:0] ReadData2,
  output logic [XLEN_P-1:0] WriteData,
  output logic [CNT_W-1:0]  WriteCount
);

  logic [XLEN_P-1:0] regs [NREG_P];
  logic [CNT_W-1:0]  writeCountR;
  logic              commitEn;

  wb_select #(
    .XLEN_P (XLEN_P)
  ) uSelect (
    .MemToReg  (MemToReg),
    .RegWrite  (RegWrite),
    .ReadData  (ReadData),
    .AluResult (AluResult),
    .rd        (rd),
    .WriteData (WriteData),
    .commitEn  (commitEn)
  );

  // Register array: cleared asynchronously, written on commit. x0 is never
  // written because commitEn already excludes rd == x0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG_P; i++) begin
        regs[i] <= {XLEN_P{1'b0}};
      end
    end else if (commitEn) begin
      regs[rd] <= WriteData;
    end else begin
      regs[rd] <= regs[rd];
    end
  end

  // Retired-write counter, free-running wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeCountR <= {CNT_W{1'b0}};
    end else if (commitEn) begin
      writeCountR <= writeCountR + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      writeCountR <= writeCountR;
    end
  end

  assign WriteCount = writeCountR;

  // Read port 1: forced to zero in reset (bypass would otherwise leak
  // WriteData), then x0, then same-cycle bypass, then stored value.
  always_comb begin
    ReadData1 = {XLEN_P{1'b0}};
    if (!reset) begin
      ReadData1 = {XLEN_P{1'b0}};
    end else if (rs1 == REG_ZERO) begin
      ReadData1 = {XLEN_P{1'b0}};
    end else if (commitEn && (rs1 == rd)) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs[rs1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    ReadData2 = {XLEN_P{1'b0}};
    if (!reset) begin
      ReadData2 = {XLEN_P{1'b0}};
    end else if (rs2 == REG_ZERO) begin
      ReadData2 = {XLEN_P{1'b0}};
    end else if (commitEn && (rs2 == rd)) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs[rs2];
    end
  end

endmodule : wb_regfile

// File: doc/wb_regfile.md
# wb_regfile

Writeback sink for the five-stage RISC-V pipeline: consumes the registered MEM/WB stage outputs and commits results into the integer register file. Selects the writeback value (memory load data vs. ALU result), performs the register write on the clock edge and serves the two ID-stage read ports. Reads are write-first bypassed so the ID stage never sees a stale value for an instruction retiring in the same cycle. Also keeps a retired-write counter for debug and performance.

## Interface
- XLEN, 64, datapath and register width
- NREG, 32, architectural register count; fixed at 32 by the 5-bit specifiers
- CNT_W, 32, width of the retired-write counter
- clk  input  1  pipeline clock, rising-edge
- reset  input  1  asynchronous, active-low (0 = reset asserted); one clock domain
- MemToReg  input  1  1 selects ReadData, 0 selects AluResult
- RegWrite  input  1  writeback enable for this cycle
- ReadData  input  XLEN  load data from MEM/WB
- AluResult  input  XLEN  ALU result from MEM/WB
- rd  input  5  destination register
- rs1  input  5  read port 1 address (ID stage)
- rs2  input  5  read port 2 address (ID stage)
- ReadData1  output  XLEN  combinational read port 1
- ReadData2  output  XLEN  combinational read port 2
- WriteData  output  XLEN  selected writeback value, for the forwarding unit
- WriteCount  output  CNT_W  number of committed writes since reset

## Operation
- WriteData = MemToReg ? ReadData : AluResult. Purely combinational, valid regardless of RegWrite.
- Commit condition: RegWrite == 1 and rd != 0.
- On a rising clk edge with the commit condition true: regs[rd] <= WriteData and WriteCount <= WriteCount + 1.
- Register x0 is hardwired to 0. Writes to x0 are discarded and do not increment WriteCount.
- Read port n returns a value chosen in priority order:
  - rsN == 0: returns 0.
  - Commit condition true and rsN == rd: returns WriteData (bypass).
  - Otherwise: returns regs[rsN].
- rs1 == rs2 == rd: both ports return the bypassed WriteData.
- WriteCount wraps modulo 2^CNT_W with no saturation and no flag.
- Asynchronous reset (reset == 0): all regs clear to 0 and WriteCount clears to 0 immediately, without waiting for clk.
  - During reset, ReadData1, ReadData2 and WriteCount read 0.
  - WriteData still follows its inputs.
  - A commit on the same edge that reset is asserted is lost.
- Reset deassertion is assumed synchronised upstream. The first edge with reset == 1 may commit.
- X on rd/rs while RegWrite == 0 must not corrupt state.

## Timing
- Write latency: 1 cycle. The value is stored at the edge that ends the MEM/WB cycle.
- The bypass makes the value visible on the read ports in the same cycle (0-cycle read-after-write).
- Read ports and WriteData are combinational, with no added register stage.
- WriteCount updates at the same edge as the register write.

## Structure
- Shared package riscv_pkg:
  - XLEN, NREG and REG_ZERO (5'd0)
  - a reg_addr_t 5-bit typedef
- One sub-module, wb_select: the MemToReg mux plus the commit-condition decode (RegWrite and rd != 0). It is reused by the forwarding unit.
- Register array, bypass and counter live in wb_regfile itself.

## Test plan
- Assert reset low mid-cycle after prior writes:
  - regs and WriteCount read 0 immediately, without a clk edge.
  - After release, reading x5 gives 0.
- Commit from the ALU path (RegWrite=1, MemToReg=0, AluResult=64'hDEAD_BEEF_0000_0001, rd=5), then read rs1=5 next cycle -> ReadData1=64'hDEAD_BEEF_0000_0001, WriteCount=1.
- Commit from the load path (MemToReg=1, ReadData=64'h0123_4567_89AB_CDEF, AluResult=64'hFFFF, rd=7) with rs2=7 in the same cycle -> ReadData2 shows 64'h0123_4567_89AB_CDEF before the edge (bypass) and after it (stored).
- Write x0 (RegWrite=1, rd=0, AluResult=64'h1) with rs1=0 -> ReadData1=0 before and after the edge, WriteCount unchanged.
- RegWrite=0, rd=3, AluResult=64'h55 while x3 holds 64'h22 -> rs1=3 reads 64'h22, no bypass, no count.
- Preload WriteCount to 2^CNT_W-1 via back-to-back commits (or force), then perform one commit -> WriteCount wraps to 0.
